demux_stream: RTL and testbench

- Registered 1:2 stream demultiplexer, the inverse of the team's 2:1 nibble mux: one 4-bit input stream is steered to output lane zero or lane one by a per-beat select.
- Each lane has its own small FIFO and valid/ready handshake, so a stalled lane never blocks the other lane once its beat is buffered.
- Sits between a single producer and two independent consumers.
- Also keeps per-lane wrap-around transfer counters for debug.

---
 rtl/demux_stream.sv | 100 ++++++++++
 tb/tb_demux_stream.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/demux_stream.sv
// Registered 1:2 stream demultiplexer: each input beat is steered by insel into
// one of two independent lane FIFOs, each with its own valid/ready handshake.
module demux_stream #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2,
    parameter int CNTW  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             invalid,
    output logic             inready,
    input  logic [WIDTH-1:0] indata,
    input  logic             insel,
    output logic             outzerovalid,
    input  logic             outzeroready,
    output logic [WIDTH-1:0] outzerodata,
    output logic             outonevalid,
    input  logic             outoneready,
    output logic [WIDTH-1:0] outonedata,
    output logic [CNTW-1:0]  cntzero,
    output logic [CNTW-1:0]  cntone
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);
    localparam logic [PW:0] CNT_ONE  = (PW+1)'(1);

    typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} lane_state_t;

    logic [1:0]       lane_full;
    logic [1:0]       lane_valid;
    logic [1:0]       lane_rdy;
    logic [WIDTH-1:0] lane_data [2];
    logic [CNTW-1:0]  lane_cnt  [2];
    logic             accept;

    // Ready looks only at the registered state of the addressed lane, so no
    // combinational path exists from either consumer back to the producer.
    assign inready  = rst_n && (insel ? !lane_full[1] : !lane_full[0]);
    assign accept   = invalid && inready;
    assign lane_rdy = {outoneready, outzeroready};

    for (genvar g = 0; g < 2; g++) begin : g_lane
        logic [DEPTH-1:0][WIDTH-1:0] mem;
        logic [PW-1:0]               wptr;
        logic [PW-1:0]               rptr;
        logic [PW:0]                 count;
        lane_state_t                 state;
        logic [CNTW-1:0]             cnt;
        logic                        push;
        logic                        pop;

        assign push = accept && (insel == 1'(g));
        assign pop  = (state != EMPTY) && lane_rdy[g];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                mem   <= '0;
                wptr  <= '0;
                rptr  <= '0;
                count <= '0;
                state <= EMPTY;
                cnt   <= '0;
            end else begin
                if (push) begin
                    mem[wptr] <= indata;
                    wptr      <= wptr + 1'b1;
                    cnt       <= cnt + 1'b1;
                end
                if (pop) begin
                    rptr <= rptr + 1'b1;
                end
                unique case ({push, pop})
                    2'b10: begin
                        count <= count + 1'b1;
                        state <= (count == CNT_FULL - 1'b1) ? FULL : PARTIAL;
                    end
                    2'b01: begin
                        count <= count - 1'b1;
                        state <= (count == CNT_ONE) ? EMPTY : PARTIAL;
                    end
                    default: ;
                endcase
            end
        end

        assign lane_full[g]  = (state == FULL);
        assign lane_valid[g] = (state != EMPTY);
        assign lane_data[g]  = mem[rptr];
        assign lane_cnt[g]   = cnt;
    end

    assign outzerovalid = lane_valid[0];
    assign outzerodata  = lane_data[0];
    assign outonevalid  = lane_valid[1];
    assign outonedata   = lane_data[1];
    assign cntzero      = lane_cnt[0];
    assign cntone       = lane_cnt[1];

endmodule

// File: tb/tb_demux_stream.sv
// Directed self-checking bench for demux_stream with per-lane scoreboards
// filled on accept and drained as each lane pops.
module tb_demux_stream;

    logic       clk;
    logic       rst_n;
    logic       invalid;
    logic       inready;
    logic [3:0] indata;
    logic       insel;
    logic       outzerovalid;
    logic       outzeroready;
    logic [3:0] outzerodata;
    logic       outonevalid;
    logic       outoneready;
    logic [3:0] outonedata;
    logic [7:0] cntzero;
    logic [7:0] cntone;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [3:0]  q0[$];
    logic [3:0]  q1[$];

    demux_stream #(.WIDTH(4), .DEPTH(2), .CNTW(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .invalid(invalid), .inready(inready), .indata(indata), .insel(insel),
        .outzerovalid(outzerovalid), .outzeroready(outzeroready), .outzerodata(outzerodata),
        .outonevalid(outonevalid), .outoneready(outoneready), .outonedata(outonedata),
        .cntzero(cntzero), .cntone(cntone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Consumer-side scoreboard: compare each popped beat against the oldest expected one.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (outzerovalid && outzeroready) begin
                if (q0.size() == 0) chk("lane0_spurious_valid", outzerovalid, 0);
                else                chk("lane0_data", outzerodata, q0.pop_front());
            end
            if (outonevalid && outoneready) begin
                if (q1.size() == 0) chk("lane1_spurious_valid", outonevalid, 0);
                else                chk("lane1_data", outonedata, q1.pop_front());
            end
        end
    end

    task automatic send(input logic sel, input logic [3:0] d);
        int unsigned waited = 0;
        invalid = 1'b1;
        insel   = sel;
        indata  = d;
        @(negedge clk);
        while (!inready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("send_accept", inready, 1);
        if (inready) begin
            if (sel) q1.push_back(d);
            else     q0.push_back(d);
        end
        @(posedge clk);
        #1;
        invalid = 1'b0;
    endtask

    task automatic do_reset(input int unsigned n);
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        repeat (n) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; invalid = 1'b0; indata = '0; insel = 1'b0;
        outzeroready = 1'b0; outoneready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_inready", inready, 0);
        chk("rst_valid0", outzerovalid, 0);
        chk("rst_valid1", outonevalid, 0);
        chk("rst_data0", outzerodata, 0);
        chk("rst_data1", outonedata, 0);
        chk("rst_cnt0", cntzero, 0);
        chk("rst_cnt1", cntone, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_inready", inready, 1);
        @(posedge clk); #1;

        // Basic steering, one cycle latency
        outzeroready = 1'b1; outoneready = 1'b1;
        send(1'b0, 4'hA);
        @(negedge clk);
        chk("lat_valid0", outzerovalid, 1);
        chk("lat_data0", outzerodata, 4'hA);
        @(posedge clk); #1;
        send(1'b1, 4'h5);
        @(negedge clk);
        chk("lat_valid1", outonevalid, 1);
        @(posedge clk); #1;
        send(1'b0, 4'hC);
        repeat (3) @(posedge clk); #1;
        chk("basic_q0_empty", q0.size(), 0);
        chk("basic_q1_empty", q1.size(), 0);
        chk("basic_cnt0", cntzero, 2);
        chk("basic_cnt1", cntone, 1);

        // Back-pressure isolation
        outzeroready = 1'b0;
        send(1'b0, 4'h1);
        send(1'b0, 4'h2);
        invalid = 1'b1; insel = 1'b0; indata = 4'h3;
        @(negedge clk);
        chk("bp_full_ready", inready, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_full_ready_hold", inready, 0);
        @(posedge clk); #1;
        insel = 1'b1; indata = 4'h7;
        @(negedge clk);
        chk("bp_other_lane_ready", inready, 1);
        if (inready) q1.push_back(4'h7);
        @(posedge clk); #1;
        invalid = 1'b0;
        @(negedge clk);
        chk("bp_valid1", outonevalid, 1);
        chk("bp_data1", outonedata, 4'h7);
        chk("bp_valid0_held", outzerovalid, 1);
        chk("bp_data0_held", outzerodata, 4'h1);
        insel = 1'b0;
        #1;
        chk("bp_lane0_still_full", inready, 0);
        @(posedge clk); #1;
        outzeroready = 1'b1;
        @(negedge clk);
        chk("bp_ready_not_same_cycle", inready, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_ready_next_cycle", inready, 1);
        repeat (3) @(posedge clk); #1;
        chk("bp_q0_drained", q0.size(), 0);

        // Simultaneous push and pop on lane zero
        for (int i = 0; i < 8; i++) begin
            invalid = 1'b1; insel = 1'b0; indata = 4'(i + 3);
            @(negedge clk);
            chk("pp_ready", inready, 1);
            chk("pp_valid0", outzerovalid, (i > 0) ? 1 : 0);
            if (inready) q0.push_back(4'(i + 3));
            @(posedge clk); #1;
        end
        invalid = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk("pp_q0_drained", q0.size(), 0);
        chk("pp_valid0_idle", outzerovalid, 0);
        chk("pp_cnt0", cntzero, 12);
        chk("pp_cnt1", cntone, 2);

        // Counter wrap on lane one
        do_reset(2);
        outoneready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            send(1'b1, 4'($urandom_range(15, 0)));
            if (i == 254) chk("wrap_cnt1_max", cntone, 255);
        end
        chk("wrap_cnt1_zero", cntone, 0);
        chk("wrap_cnt0_zero", cntzero, 0);
        repeat (3) @(posedge clk); #1;
        chk("wrap_q1_drained", q1.size(), 0);

        // Asynchronous reset mid-operation
        outzeroready = 1'b0; outoneready = 1'b0;
        send(1'b0, 4'hD);
        send(1'b0, 4'hE);
        send(1'b1, 4'h6);
        @(negedge clk);
        chk("mid_valid0", outzerovalid, 1);
        chk("mid_valid1", outonevalid, 1);
        #2;
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        #1;
        chk("mid_rst_valid0", outzerovalid, 0);
        chk("mid_rst_valid1", outonevalid, 0);
        chk("mid_rst_cnt0", cntzero, 0);
        chk("mid_rst_cnt1", cntone, 0);
        chk("mid_rst_inready", inready, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        outzeroready = 1'b1; outoneready = 1'b1;
        send(1'b1, 4'h9);
        @(negedge clk);
        chk("post_valid1", outonevalid, 1);
        chk("post_data1", outonedata, 4'h9);
        chk("post_valid0", outzerovalid, 0);
        repeat (3) @(posedge clk); #1;
        chk("post_q1_drained", q1.size(), 0);
        chk("post_valid1_idle", outonevalid, 0);
        chk("post_cnt1", cntone, 1);
        chk("post_cnt0", cntzero, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
